mul_flag_unit: RTL and testbench

Iterative 32x32 multiply(-accumulate) unit in the execute stage. It produces the low 32-bit result together with the `ALUFlagsM` and `FlagWriteM` pair that the flag-register and condition-check logic consume; it is the producer side of that flag interface. It runs multi-cycle, stalls the pipeline while busy, and writes only N and Z. C and V are returned unchanged.

---
 rtl/mul_flag_unit.sv | 92 +++++++++
 tb/tb_mul_flag_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_flag_unit.sv
// mul_flag_unit: iterative shift-add multiply(-accumulate) producing the low result plus N/Z flags,
// passing C/V through from start time, with a one-cycle DoneM pulse and BusyE stall while running.
module mul_flag_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             StartE,
    input  logic             FlushE,
    input  logic             AccE,
    input  logic             SetFlagsE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic [WIDTH-1:0] AccSrcE,
    input  logic [3:0]       FlagsE,
    output logic             BusyE,
    output logic             DoneM,
    output logic [WIDTH-1:0] ResultM,
    output logic [3:0]       ALUFlagsM,
    output logic [1:0]       FlagWriteM
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_mcand, r_mplier, r_acc, r_result;
    logic [CW-1:0]    r_cnt;
    logic             r_sflag;
    logic [1:0]       r_cv;
    logic [3:0]       r_flags;
    logic             w_accept, w_last, w_unused;
    logic [WIDTH-1:0] w_sum;

    assign w_unused = ^FlagsE[3:2];
    assign w_accept = (r_state != RUN) && StartE && !FlushE;
    assign w_last   = (r_state == RUN) && (r_cnt == LAST);
    assign w_sum    = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_next = r_state;
        if (FlushE)
            w_next = IDLE;
        else if (w_accept)
            w_next = RUN;
        else if (r_state == RUN)
            w_next = w_last ? DONE : RUN;
        else
            w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sflag  <= 1'b0;
            r_cv     <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_mcand  <= SrcAE;
                r_mplier <= SrcBE;
                r_acc    <= AccE ? AccSrcE : '0;
                r_cnt    <= '0;
                r_sflag  <= SetFlagsE;
                r_cv     <= FlagsE[1:0];
            end else if (r_state == RUN) begin
                r_acc    <= w_sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CW'(1);
                // Result is latched on the final iteration so it holds after DONE; an abort leaves the old one.
                if (w_last && !FlushE) begin
                    r_result <= w_sum;
                    r_flags  <= {w_sum[WIDTH-1], w_sum == '0, r_cv};
                end
            end
        end
    end

    assign BusyE      = (r_state == RUN);
    assign DoneM      = (r_state == DONE);
    assign ResultM    = r_result;
    assign ALUFlagsM  = r_flags;
    assign FlagWriteM = {DoneM && r_sflag, 1'b0};
endmodule

// File: tb/tb_mul_flag_unit.sv
// tb_mul_flag_unit: directed vectors push expected results into a queue; a negedge monitor
// pops and checks whenever DoneM pulses, including the cycle on which it arrives.
module tb_mul_flag_unit;
    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        logic [1:0]  fw;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        StartE = 1'b0, FlushE = 1'b0, AccE = 1'b0, SetFlagsE = 1'b0;
    logic [31:0] SrcAE = '0, SrcBE = '0, AccSrcE = '0;
    logic [3:0]  FlagsE = '0;
    logic        BusyE, DoneM;
    logic [31:0] ResultM;
    logic [3:0]  ALUFlagsM;
    logic [1:0]  FlagWriteM;

    exp_t q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    mul_flag_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .StartE(StartE), .FlushE(FlushE), .AccE(AccE),
        .SetFlagsE(SetFlagsE), .SrcAE(SrcAE), .SrcBE(SrcBE), .AccSrcE(AccSrcE), .FlagsE(FlagsE),
        .BusyE(BusyE), .DoneM(DoneM), .ResultM(ResultM), .ALUFlagsM(ALUFlagsM), .FlagWriteM(FlagWriteM)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (DoneM) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: DoneM=1 with nothing outstanding (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                check("result", ResultM, e.res);
                check("flags", {28'd0, ALUFlagsM}, {28'd0, e.flg});
                check("flagwrite", {30'd0, FlagWriteM}, {30'd0, e.fw});
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Called just after a rising edge; the start is sampled on the next edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic acc_en,
                         input logic [31:0] acc, input logic s, input logic [3:0] flags,
                         input logic [31:0] eres, input logic [3:0] eflg, input logic [1:0] efw,
                         input bit push);
        SrcAE = a;
        SrcBE = b;
        AccE = acc_en;
        AccSrcE = acc;
        SetFlagsE = s;
        FlagsE = flags;
        StartE = 1'b1;
        if (push) q.push_back('{eres, eflg, efw, cyc + 33});
        @(posedge clk);
        #1;
        StartE = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
        #1;
    endtask

    task automatic quiet(input int n);
        repeat (n) begin
            @(negedge clk);
            check("busy_quiet", {31'd0, BusyE}, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, BusyE}, 32'd0);
        check("rst_done", {31'd0, DoneM}, 32'd0);
        check("rst_result", ResultM, 32'd0);
        check("rst_flags", {28'd0, ALUFlagsM}, 32'd0);
        check("rst_fw", {30'd0, FlagWriteM}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        issue(32'd3, 32'd5, 1'b0, 32'd0, 1'b1, 4'b0011, 32'd15, 4'b0011, 2'b10, 1);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check("busy_run", {31'd0, BusyE}, 32'd1);
        end
        @(negedge clk);
        check("busy_in_done", {31'd0, BusyE}, 32'd0);
        check("done_pulse", {31'd0, DoneM}, 32'd1);
        @(negedge clk);
        check("done_one_cycle", {31'd0, DoneM}, 32'd0);
        check("fw_after_done", {30'd0, FlagWriteM}, 32'd0);
        check("result_held", ResultM, 32'd15);
        @(posedge clk);
        #1;

        issue(32'h8000_0000, 32'd1, 1'b0, 32'd0, 1'b1, 4'b0000, 32'h8000_0000, 4'b1000, 2'b10, 1);
        drain();
        issue(32'h0001_0000, 32'h0001_0000, 1'b0, 32'd0, 1'b1, 4'b0010, 32'd0, 4'b0110, 2'b10, 1);
        drain();
        issue(32'h0001_0000, 32'h0001_0000, 1'b0, 32'd0, 1'b0, 4'b0010, 32'd0, 4'b0110, 2'b00, 1);
        drain();

        // (-1)*(-1) wraps to 1; C/V must come from the start-time flags.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd2, 1'b1, 4'b0001, 32'd3, 4'b0001, 2'b10, 1);
        FlagsE = 4'b1110;
        drain();

        issue(32'd5, 32'd7, 1'b0, 32'd0, 1'b1, 4'b0000, 32'd0, 4'b0000, 2'b00, 0);
        repeat (9) @(posedge clk);
        #1;
        FlushE = 1'b1;
        @(posedge clk);
        #1;
        FlushE = 1'b0;
        quiet(40);
        check("flush_result_held", ResultM, 32'd3);
        check("flush_flags_held", {28'd0, ALUFlagsM}, 32'b0001);

        issue(32'd5, 32'd7, 1'b0, 32'd0, 1'b1, 4'b0000, 32'd0, 4'b0000, 2'b00, 0);
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("mrst_busy", {31'd0, BusyE}, 32'd0);
        check("mrst_done", {31'd0, DoneM}, 32'd0);
        check("mrst_result", ResultM, 32'd0);
        check("mrst_flags", {28'd0, ALUFlagsM}, 32'd0);
        check("mrst_fw", {30'd0, FlagWriteM}, 32'd0);
        quiet(40);

        SrcAE = 32'd7;
        SrcBE = 32'd6;
        AccE = 1'b0;
        SetFlagsE = 1'b1;
        FlagsE = 4'b0000;
        StartE = 1'b1;
        q.push_back('{32'd42, 4'b0000, 2'b10, cyc + 33});
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            SrcAE = 32'd9 + i;
            SrcBE = 32'd100 + i;
        end
        StartE = 1'b0;
        drain();

        issue(32'd11, 32'd13, 1'b0, 32'd0, 1'b1, 4'b0000, 32'd143, 4'b0000, 2'b10, 1);
        repeat (32) @(posedge clk);
        #1;
        check("b2b_in_done", {31'd0, DoneM}, 32'd1);
        issue(32'd100, 32'd100, 1'b0, 32'd0, 1'b0, 4'b0011, 32'd10000, 4'b0011, 2'b00, 1);
        check("b2b_no_bubble", {31'd0, BusyE}, 32'd1);
        drain();

        StartE = 1'b1;
        FlushE = 1'b1;
        @(posedge clk);
        #1;
        StartE = 1'b0;
        FlushE = 1'b0;
        quiet(40);
        check("startflush_result", ResultM, 32'd10000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
